// File: rtl/mult_unit_pkg.sv
// Shared types and constants for the multicycle HI/LO multiplier.
package mult_unit_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mult_unit_adder.sv
// Ripple-carry adder used for the accumulate step of the shift-and-add multiplier.

// 1-bit full-adder cell.
module mul_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// WIDTH-bit ripple-carry adder with carry-out (33-bit result for WIDTH=32).
module mul_adder33
    import mult_unit_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;
    assign cout     = carry[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        mul_fa u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

endmodule

// File: rtl/mult_unit.sv
// Multicycle WIDTHxWIDTH -> 2*WIDTH multiplier for MULT/MULTU (HI/LO result).
// Radix-2 shift-and-add on operand magnitudes; the product is negated at the end
// when the signed operands had opposite signs.
module mult_unit
    import mult_unit_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state;
    // acc_hi drops the always-zero 33rd bit: after the right shift it only ever
    // holds the adder's carry-out in its MSB, which lands in bit WIDTH-1 here.
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   mcand;
    logic [CNT_W-1:0]   cnt;
    logic               neg;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    // Add the multiplicand only when the current multiplier bit is set.
    always_comb begin
        add_b = acc_lo[0] ? mcand : '0;
    end

    mul_adder33 #(.WIDTH(WIDTH)) u_add (
        .a    (acc_hi),
        .b    (add_b),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Operand magnitudes for signed operation; 0x80000000 stays as unsigned 2^31.
    always_comb begin
        mag_a = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        mag_b = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    end

    // Final sign fix of the accumulated product; ~0+1 wraps to 0, so no -0.
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg ? (~prod + (2*WIDTH)'(1)) : prod;
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            mcand  <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand  <= mag_a;
                        acc_hi <= '0;
                        acc_lo <= mag_b;
                        neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc_hi <= {add_cout, add_sum[WIDTH-1:1]};
                    acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    hi    <= prod_fix[2*WIDTH-1:WIDTH];
                    lo    <= prod_fix[WIDTH-1:0];
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed vectors, randomized operands against
// a plain-arithmetic product model, start-while-busy, back-to-back and mid-op reset.
module tb_mult_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests_run    = 0;
    int tests_failed = 0;

    mult_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product: full 64-bit integer multiply of the operands.
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic s);
        longint sx;
        longint sy;
        logic [63:0] ux;
        logic [63:0] uy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        ux = {32'd0, x};
        uy = {32'd0, y};
        return ux * uy;
    endfunction

    // Present operands for one edge, then scramble the inputs; returns at the
    // negedge of the first cycle after the sampling edge (cycle count 1).
    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic s);
        @(negedge clk);
        a = x; b = y; is_signed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
    endtask

    // Advance by negedges until done is seen; lat is the cycle count since start.
    task automatic wait_done(inout int lat);
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %0b want 0", busy); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %0b want 0", done); end
        tests_run++;
        if (hi !== 32'h0) begin tests_failed++; $display("FAIL reset_hi got %08h want 0", hi); end
        tests_run++;
        if (lo !== 32'h0) begin tests_failed++; $display("FAIL reset_lo got %08h want 0", lo); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [31:0] va [8] = '{32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'h80000000, 32'h80000000, 32'h0, 32'h0};
        logic [31:0] vb [8] = '{32'd6, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h0};
        logic        vs [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] eh [8] = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0,
                                32'h40000000, 32'hFFFFFFFF, 32'h0, 32'h0};
        logic [31:0] el [8] = '{32'h2A, 32'hFFFFFFF1, 32'h1, 32'h1,
                                32'h0, 32'h80000000, 32'h0, 32'h0};
        int lat;
        logic [31:0] held_hi;
        logic [31:0] held_lo;
        for (int i = 0; i < 8; i++) begin
            start_op(va[i], vb[i], vs[i]);
            tests_run++;
            if (busy !== 1'b1) begin tests_failed++; $display("FAIL dir%0d_busy got %0b want 1", i, busy); end
            lat = 1;
            wait_done(lat);
            tests_run++;
            if (lat != 34) begin tests_failed++; $display("FAIL dir%0d_latency got %0d want 34", i, lat); end
            tests_run++;
            if (hi !== eh[i]) begin tests_failed++; $display("FAIL dir%0d_hi got %08h want %08h", i, hi, eh[i]); end
            tests_run++;
            if (lo !== el[i]) begin tests_failed++; $display("FAIL dir%0d_lo got %08h want %08h", i, lo, el[i]); end
            held_hi = eh[i];
            held_lo = el[i];
            repeat (3) @(negedge clk);
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                tests_failed++; $display("FAIL dir%0d_idle got done=%0b busy=%0b want 0 0", i, done, busy);
            end
            tests_run++;
            if (hi !== held_hi || lo !== held_lo) begin
                tests_failed++; $display("FAIL dir%0d_hold got %08h_%08h want %08h_%08h", i, hi, lo, held_hi, held_lo);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        logic [63:0] exp_p;
        int lat;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0: x = 32'h80000000;
                1: x = 32'hFFFFFFFF;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: y = 32'h80000000;
                1: y = 32'h1;
                default: y = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            exp_p = ref_mul(x, y, s);
            start_op(x, y, s);
            lat = 1;
            wait_done(lat);
            tests_run++;
            if (lat != 34) begin tests_failed++; $display("FAIL rnd%0d_latency got %0d want 34", i, lat); end
            tests_run++;
            if ({hi, lo} !== exp_p) begin
                tests_failed++;
                $display("FAIL rnd%0d_product a=%08h b=%08h s=%0b got %08h_%08h want %016h", i, x, y, s, hi, lo, exp_p);
            end
        end
    endtask

    task automatic test_start_while_busy;
        int n;
        logic [63:0] exp_p;
        start_op(32'd3, 32'd4, 1'b0);
        n = 1;
        while (n < 5) begin @(negedge clk); n++; end
        a = 32'd9; b = 32'd9; is_signed = 1'b0; start = 1'b1;
        @(negedge clk); n++;
        start = 1'b0;
        wait_done(n);
        tests_run++;
        if (n != 34) begin tests_failed++; $display("FAIL busy_start_latency got %0d want 34", n); end
        tests_run++;
        if (hi !== 32'h0 || lo !== 32'hC) begin
            tests_failed++; $display("FAIL busy_start_result got %08h_%08h want 00000000_0000000c", hi, lo);
        end
        // Back-to-back: new start during the DONE cycle.
        a = 32'h00012345; b = 32'h00001000; is_signed = 1'b0; start = 1'b1;
        exp_p = ref_mul(32'h00012345, 32'h00001000, 1'b0);
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_accept got busy=%0b done=%0b want 1 0", busy, done);
        end
        n = 1;
        wait_done(n);
        tests_run++;
        if (n != 34) begin tests_failed++; $display("FAIL b2b_latency got %0d want 34", n); end
        tests_run++;
        if ({hi, lo} !== exp_p) begin
            tests_failed++; $display("FAIL b2b_product got %08h_%08h want %016h", hi, lo, exp_p);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        start_op(32'hDEADBEEF, 32'h00001234, 1'b0);
        n = 1;
        while (n < 10) begin @(negedge clk); n++; end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_ctrl got busy=%0b done=%0b want 0 0", busy, done);
        end
        tests_run++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            tests_failed++; $display("FAIL midrst_hilo got %08h_%08h want 0_0", hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_op(32'd2, 32'd3, 1'b0);
        n = 1;
        wait_done(n);
        tests_run++;
        if (n != 34) begin tests_failed++; $display("FAIL postrst_latency got %0d want 34", n); end
        tests_run++;
        if (hi !== 32'h0 || lo !== 32'h6) begin
            tests_failed++; $display("FAIL postrst_result got %08h_%08h want 00000000_00000006", hi, lo);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
